// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU with registered results and iterative MULU/DIVU
// Logic ops, ADD, SUB and SLT finish at the accept edge; MULU and DIVU take WIDTH BUSY cycles.
module alu_multicycle #(
    parameter int WIDTH      = 32,
    parameter int SIGNED_SLT = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OPS,
    output logic             ZF,
    output logic             CF,
    output logic             DZ,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_MULU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_ops;
    logic             r_zf;
    logic             r_cf;
    logic             r_dz;

    logic             w_accept;
    logic             w_multi;
    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_cf;
    logic             w_sc_dz;

    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_tr;
    logic             w_div_ok;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_accept = IN_VALID && (r_state == S_IDLE);
    assign w_multi  = (OP == OP_MULU) || ((OP == OP_DIVU) && (OP2 != '0));
    assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);

    assign w_sum  = {1'b0, OP1} + {1'b0, OP2};
    assign w_diff = {1'b0, OP1} - {1'b0, OP2};
    assign w_slt  = (SIGNED_SLT != 0) ? ($signed(OP1) < $signed(OP2)) : (OP1 < OP2);

    always_comb begin
        w_sc_res = '0;
        w_sc_cf  = 1'b0;
        w_sc_dz  = 1'b0;
        case (OP)
            OP_AND:  w_sc_res = OP1 & OP2;
            OP_OR:   w_sc_res = OP1 | OP2;
            OP_ADD:  begin w_sc_res = w_sum[WIDTH-1:0];  w_sc_cf = w_sum[WIDTH];  end
            OP_SUB:  begin w_sc_res = w_diff[WIDTH-1:0]; w_sc_cf = w_diff[WIDTH]; end
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_DIVU: begin w_sc_res = '1; w_sc_dz = 1'b1; end
            OP_NOR:  w_sc_res = ~(OP1 | OP2);
            default: w_sc_res = '0;
        endcase
    end

    // r_hi/r_lo are shared: remainder/dividend-quotient for DIVU, product high/low for MULU.
    assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_tr  = w_div_sh - {1'b0, r_b};
    assign w_div_ok  = ~w_div_tr[WIDTH];
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    always_comb begin
        w_step_hi = w_div_ok ? w_div_tr[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_step_lo = {r_lo[WIDTH-2:0], w_div_ok};
        if (r_op == OP_MULU) begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_multi ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == '0) w_next = S_DONE;
            S_DONE: if (OUT_READY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_ops <= '0;
            r_zf  <= 1'b0;
            r_cf  <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= OP1;
            r_b   <= OP2;
            r_op  <= OP;
            r_cnt <= CW'(WIDTH - 1);
            r_hi  <= '0;
            r_lo  <= (OP == OP_MULU) ? OP2 : OP1;
            if (!w_multi) begin
                r_ops <= w_sc_res;
                r_zf  <= (w_sc_res == '0);
                r_cf  <= w_sc_cf;
                r_dz  <= w_sc_dz;
            end
        end else if (r_state == S_BUSY) begin
            r_hi <= w_step_hi;
            r_lo <= w_step_lo;
            if (w_last) begin
                r_ops <= w_step_lo;
                r_zf  <= (w_step_lo == '0);
                r_cf  <= (r_op == OP_MULU) && (w_step_hi != '0);
                r_dz  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign IN_READY  = (r_state == S_IDLE) && !RESET;
    assign OUT_VALID = (r_state == S_DONE);
    assign BUSY      = (r_state != S_IDLE);
    assign OPS       = r_ops;
    assign ZF        = r_zf;
    assign CF        = r_cf;
    assign DZ        = r_dz;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed-vector bench for alu_multicycle at WIDTH=32 and WIDTH=8
module tb_alu_multicycle;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_MULU = 3'b111;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    logic        a_in_valid  = 1'b0;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_op1       = '0;
    logic [31:0] a_op2       = '0;
    logic [2:0]  a_op        = '0;
    logic        a_in_ready, a_out_valid, a_zf, a_cf, a_dz, a_busy;
    logic [31:0] a_ops;

    logic        b_in_valid  = 1'b0;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_op1       = '0;
    logic [7:0]  b_op2       = '0;
    logic [2:0]  b_op        = '0;
    logic        b_in_ready, b_out_valid, b_zf, b_cf, b_dz, b_busy;
    logic [7:0]  b_ops;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int ov_seen;

    alu_multicycle #(.WIDTH(32), .SIGNED_SLT(0)) u_alu32 (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
        .OP1(a_op1), .OP2(a_op2), .OP(a_op),
        .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready),
        .OPS(a_ops), .ZF(a_zf), .CF(a_cf), .DZ(a_dz), .BUSY(a_busy)
    );

    alu_multicycle #(.WIDTH(8), .SIGNED_SLT(1)) u_alu8 (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
        .OP1(b_op1), .OP2(b_op2), .OP(b_op),
        .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready),
        .OPS(b_ops), .ZF(b_zf), .CF(b_cf), .DZ(b_dz), .BUSY(b_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Latency counts the accept edge as 1; OUT_VALID is sampled 1 ns after each rising edge.
    task automatic run32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int l);
        @(negedge CLK);
        a_op = op; a_op1 = x; a_op2 = y; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(posedge CLK); #1;
        a_in_valid = 1'b0;
        l = 1;
        while (!a_out_valid && l < 100) begin
            @(posedge CLK); #1;
            l++;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        output int l);
        @(negedge CLK);
        b_op = op; b_op1 = x; b_op2 = y; b_in_valid = 1'b1; b_out_ready = 1'b0;
        @(posedge CLK); #1;
        b_in_valid = 1'b0;
        l = 1;
        while (!b_out_valid && l < 100) begin
            @(posedge CLK); #1;
            l++;
        end
    endtask

    task automatic release32();
        @(negedge CLK); a_out_ready = 1'b1;
        @(posedge CLK); #1; a_out_ready = 1'b0;
    endtask

    task automatic release8();
        @(negedge CLK); b_out_ready = 1'b1;
        @(posedge CLK); #1; b_out_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk_eq("rst_outputs", {a_ops, a_out_valid, a_busy, a_zf, a_cf, a_dz}, 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk_eq("rst_in_ready", {a_in_ready, b_in_ready}, 64'b11);

        run32(OP_ADD, 32'hFFFF_FFFF, 32'd1, lat);
        chk_eq("add_lat", lat, 64'd1);
        chk_eq("add_res", {a_ops, a_zf, a_cf, a_dz}, {32'd0, 1'b1, 1'b1, 1'b0});
        release32();

        run32(OP_SUB, 32'd5, 32'd7, lat);
        chk_eq("sub_res", {a_ops, a_zf, a_cf}, {32'hFFFF_FFFE, 1'b0, 1'b1});
        release32();

        // Abandon a DIVU in its tenth BUSY cycle with an asynchronous reset.
        @(negedge CLK);
        a_op = OP_DIVU; a_op1 = 32'd100; a_op2 = 32'd7; a_in_valid = 1'b1;
        @(posedge CLK); #1;
        a_in_valid = 1'b0;
        chk_eq("div_busy", {a_busy, a_in_ready, a_out_valid}, 64'b100);
        repeat (9) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk_eq("midrst_outputs", {a_ops, a_out_valid, a_busy, a_zf, a_cf, a_dz}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk_eq("midrst_in_ready", a_in_ready, 64'd1);
        ov_seen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (a_out_valid) ov_seen++;
        end
        chk_eq("midrst_no_result", ov_seen, 64'd0);

        run32(OP_SLT, 32'd3, 32'd9, lat);
        chk_eq("slt_res", {a_ops, a_cf}, {32'd1, 1'b0});
        release32();

        run32(OP_SLT, 32'h8000_0000, 32'd1, lat);
        chk_eq("slt_unsigned", a_ops, 64'd0);
        release32();

        run32(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        chk_eq("and_res", {a_ops, a_zf, a_cf}, {32'hF000_F000, 1'b0, 1'b0});
        release32();

        run32(OP_OR, 32'h0000_00F0, 32'h0000_000F, lat);
        chk_eq("or_res", a_ops, 64'h0000_00FF);
        release32();

        run32(OP_NOR, 32'd0, 32'd0, lat);
        chk_eq("nor_res", {a_ops, a_zf}, {32'hFFFF_FFFF, 1'b0});
        release32();

        run32(OP_DIVU, 32'd100, 32'd7, lat);
        chk_eq("divu_lat", lat, 64'd33);
        chk_eq("divu_res", {a_ops, a_zf, a_cf, a_dz}, {32'd14, 1'b0, 1'b0, 1'b0});
        release32();

        run32(OP_DIVU, 32'd5, 32'd0, lat);
        chk_eq("divz_lat", lat, 64'd1);
        chk_eq("divz_res", {a_ops, a_zf, a_cf, a_dz}, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1});
        release32();

        run32(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat);
        chk_eq("divu_full", {a_ops, a_dz}, {32'hFFFF_FFFF, 1'b0});
        release32();

        run32(OP_MULU, 32'h0001_0000, 32'h0001_0000, lat);
        chk_eq("mulu_lat", lat, 64'd33);
        chk_eq("mulu_ovf", {a_ops, a_zf, a_cf}, {32'd0, 1'b1, 1'b1});
        release32();

        run32(OP_MULU, 32'd1234, 32'd5678, lat);
        chk_eq("mulu_res", {a_ops, a_zf, a_cf}, {32'd7006652, 1'b0, 1'b0});
        release32();

        // Backpressure: a new operation offered during DONE must not be taken.
        run32(OP_ADD, 32'd10, 32'd20, lat);
        a_op = OP_SUB; a_op1 = 32'd1; a_op2 = 32'd1; a_in_valid = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1;
            chk_eq("bp_hold", {a_ops, a_in_ready, a_out_valid}, {32'd30, 1'b0, 1'b1});
        end
        @(negedge CLK);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(posedge CLK); #1;
        a_out_ready = 1'b0;
        chk_eq("bp_to_idle", {a_in_ready, a_out_valid, a_ops}, {1'b1, 1'b0, 32'd30});
        run32(OP_ADD, 32'd1, 32'd1, lat);
        chk_eq("bp_next_op", {lat[7:0], a_ops}, {8'd1, 32'd2});
        release32();

        run8(OP_SLT, 8'h80, 8'h01, lat);
        chk_eq("w8_slt_signed", b_ops, 64'd1);
        release8();

        run8(OP_MULU, 8'd16, 8'd16, lat);
        chk_eq("w8_mulu", {b_ops, b_zf, b_cf}, {8'd0, 1'b1, 1'b1});
        chk_eq("w8_mulu_lat", lat, 64'd9);
        release8();

        run8(OP_DIVU, 8'hFF, 8'h10, lat);
        chk_eq("w8_divu_lat", lat, 64'd9);
        chk_eq("w8_divu", {b_ops, b_dz}, {8'h0F, 1'b0});
        release8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit ALU of the datapath.
- Width is generic, and results are registered.
- Multiply and divide are iterative multi-cycle operations, so they no longer form a combinational critical path.
- Adds carry, divide-by-zero and busy status, and correctly defines ZF as "result equals zero". Sits between the register-file read stage and write-back.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
SIGNED_SLT, 0, 1 = op 100 compares two's-complement, 0 = unsigned.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
IN_VALID  input  1  operands/opcode valid.
IN_READY  output  1  block can accept an operation.
OP1  input  WIDTH  operand A.
OP2  input  WIDTH  operand B.
OP  input  3  opcode.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  consumer accepts result.
OPS  output  WIDTH  result.
ZF  output  1  1 when OPS == 0.
CF  output  1  carry/borrow/overflow (see below).
DZ  output  1  divide-by-zero.
BUSY  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous, clears all outputs regardless of clock.
  - State = IDLE; OPS = 0; ZF, CF, DZ = 0; OUT_VALID = 0; BUSY = 0; internal counter and accumulators = 0.
  - IN_READY = 1 once RESET deasserts.
  - Reset mid-operation abandons the operation; no result is ever presented.
- States: IDLE, BUSY, DONE. IN_READY = (state == IDLE). OUT_VALID = (state == DONE).
- Accept: IN_VALID & IN_READY at a rising edge latches OP1, OP2 and OP.
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD; CF = carry out of bit WIDTH-1.
  - 011 SUB (OP1-OP2); CF = borrow (OP1 < OP2 unsigned).
  - 100 SLT; OPS = 1 or 0, CF = 0.
  - 101 DIVU; OPS = quotient.
  - 110 NOR.
  - 111 MULU; OPS = low WIDTH bits of the product; CF = 1 if the high WIDTH bits are nonzero.
  - CF = 0 for 000, 001, 110 and 101.
- Single-cycle ops (000–100, 110): IDLE -> DONE at the accepting edge. OUT_VALID is high one cycle after acceptance.
- DIVU with OP2 == 0: treated as single-cycle. OPS = all ones, DZ = 1, ZF = 0.
- DIVU with OP2 != 0: restoring shift-subtract, one quotient bit per cycle.
  - IDLE -> BUSY at accept; exactly WIDTH cycles in BUSY; BUSY -> DONE.
  - OUT_VALID rises WIDTH+1 cycles after acceptance. DZ = 0.
- MULU: shift-add, one multiplier bit per cycle, same timing as DIVU (WIDTH+1 cycles). The full 2*WIDTH product is kept internally for CF.
- Counter: counts WIDTH-1 down to 0 in BUSY; exits on 0. No wrap.
- DONE: OPS/ZF/CF/DZ stable while OUT_VALID & !OUT_READY. On OUT_VALID & OUT_READY, DONE -> IDLE.
  - OPS and flags hold their values after the handshake until overwritten by the next result.
  - IN_VALID is ignored while not IDLE, so there is no overlap. Max throughput is one single-cycle op per 2 cycles.
- ZF, CF and DZ update only on entry to DONE, together with OPS.
- IN_VALID while BUSY or DONE: ignored; the operand latches are unchanged.

Test Plan:
- WIDTH=32: reset mid-DIVU (cycle 10 of BUSY) -> outputs immediately 0, IN_READY=1 after release, no OUT_VALID pulse.
- WIDTH=32: ADD 0xFFFFFFFF+1 -> OUT_VALID at cycle+1; OPS=0, ZF=1, CF=1.
  - Then SUB 5-7 -> OPS=0xFFFFFFFE, CF=1, ZF=0.
  - Then SLT 3<9 -> OPS=1.
- WIDTH=32: DIVU 100/7 -> OUT_VALID exactly 33 cycles after accept, OPS=14, DZ=0.
  - Then DIVU 5/0 -> OUT_VALID at cycle+1, OPS=0xFFFFFFFF, DZ=1.
- WIDTH=32: MULU 0x10000*0x10000 -> OPS=0, ZF=1, CF=1, 33-cycle latency.
  - MULU 1234*5678 -> OPS=7006652, CF=0.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE while driving IN_VALID with new operands -> OPS stable, IN_READY=0, new op not accepted.
  - After OUT_READY=1 -> IDLE, then new op accepted.
- WIDTH=8, SIGNED_SLT=1:
  - SLT 0x80<0x01 -> OPS=1.
  - MULU 16*16 -> OPS=0, CF=1.
  - DIVU 0xFF/0x10 -> OPS=0x0F after 9 cycles.
